aes_key_mem: RTL and testbench

//  AES-128 key expansion with round-key storage, upstream of aes_sbox.

---
 rtl/aes_key_mem.sv | 143 ++++++++++++++
 tb/tb_aes_key_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_mem.sv
// -----------------------------------------------------------------------------
// aes_key_mem
//   AES-128 key expansion with round-key storage. Expands a 128-bit cipher key
//   into 11 round keys rk[0..10] and keeps them for the round datapath.
//   SubWord goes through the shared aes_sbox word interface. That S-box is
//   free-running and has no handshake. For this reason sboxw is held constant
//   for SBOX_WAIT cycles before new_sboxw is consumed.
//
//   Handshake: init is a one-cycle pulse, accepted only in IDLE or DONE.
//   key is sampled on that same edge. ready stays high while all 11 round
//   keys are valid. ready drops on the edge that accepts a restart.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous reset, active low
//   init       in   1    start expansion of key
//   key        in   128  cipher key
//   ready      out  1    all round keys valid
//   round      in   4    round-key read index (0..10; others read as 0)
//   round_key  out  128  registered rk[round], one-cycle read latency
//   sboxw      out  32   word to aes_sbox
//   new_sboxw  in   32   substituted word from aes_sbox
// -----------------------------------------------------------------------------
module aes_key_mem #(
  parameter int SBOX_WAIT = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [127:0] key,
  output logic         ready,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  localparam int WAIT_W = (SBOX_WAIT > 1) ? $clog2(SBOX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SBOX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, SUB, CALC, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_ctr;
  logic [3:0]        round_ctr;
  logic [7:0]        rcon;
  logic [31:0]       w0, w1, w2, w3;
  logic [127:0]      rk [0:10];

  logic              load;
  logic              calc;
  logic              wait_done;
  logic              last_round;
  logic [31:0]       t;
  logic [31:0]       w0n, w1n, w2n, w3n;
  logic [127:0]      rk_sel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (init) state_next = SUB;
      SUB:        if (wait_done) state_next = CALC;
      CALC:       state_next = last_round ? DONE : SUB;
      default:    state_next = IDLE;
    endcase
  end

  // Decoded controls and the combinational round function
  always_comb begin
    load       = ((state == IDLE) || (state == DONE)) && init;
    calc       = (state == CALC);
    wait_done  = (state == SUB) && (wait_ctr == WAIT_LAST);
    last_round = (round_ctr == 4'd10);
    t   = new_sboxw ^ {rcon, 24'h0};
    w0n = w0 ^ t;
    w1n = w1 ^ w0n;
    w2n = w2 ^ w1n;
    w3n = w3 ^ w2n;
    rk_sel = '0;
    for (int i = 0; i < 11; i++) begin
      if (round == 4'(i)) rk_sel = rk[i];
    end
  end

  // Datapath. sboxw is loaded with RotWord of the *next* w3 on the same edge
  // that enters SUB, so the word is already stable on the first SUB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      sboxw     <= '0;
      round_key <= '0;
      wait_ctr  <= '0;
      round_ctr <= '0;
      rcon      <= 8'h01;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      round_key <= rk_sel;
      if (load) begin
        rk[0]     <= key;
        w0        <= key[127:96];
        w1        <= key[95:64];
        w2        <= key[63:32];
        w3        <= key[31:0];
        round_ctr <= 4'd1;
        rcon      <= 8'h01;
        wait_ctr  <= '0;
        ready     <= 1'b0;
        sboxw     <= {key[23:0], key[31:24]};
      end else if (state == SUB) begin
        wait_ctr <= wait_ctr + 1'b1;
      end else if (calc) begin
        w0   <= w0n;
        w1   <= w1n;
        w2   <= w2n;
        w3   <= w3n;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        for (int i = 1; i < 11; i++) begin
          if (round_ctr == 4'(i)) rk[i] <= {w0n, w1n, w2n, w3n};
        end
        if (last_round) begin
          ready <= 1'b1;
        end else begin
          round_ctr <= round_ctr + 4'd1;
          wait_ctr  <= '0;
          sboxw     <= {w3n[23:0], w3n[31:24]};
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_mem.sv
// -----------------------------------------------------------------------------
// tb_aes_key_mem
//   Two key-expansion instances share the same stimulus. One instance uses
//   SBOX_WAIT=10 and the other uses SBOX_WAIT=12. Each instance is fed by a
//   free-running model of aes_sbox that runs a 5-phase loop. Phase 0 captures
//   sboxw. Phases 1..4 substitute one byte each through the FIPS-197 S-box.
//   The bench compares the results against the published round keys.
// -----------------------------------------------------------------------------
module tb_aes_key_mem;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         init = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   round = '0;
  logic         ready, ready2;
  logic [127:0] round_key, round_key2;
  logic [31:0]  sboxw, sboxw2;
  logic [31:0]  new_sboxw = '0;
  logic [31:0]  new_sboxw2 = '0;

  aes_key_mem #(.SBOX_WAIT(10)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .ready(ready),
    .round(round), .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw)
  );

  aes_key_mem #(.SBOX_WAIT(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .ready(ready2),
    .round(round), .round_key(round_key2), .sboxw(sboxw2), .new_sboxw(new_sboxw2)
  );

  // ---------------- S-box ROM and free-running aes_sbox model ----------------
  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_BITS[2047 - 8*int'(b) -: 8];
  endfunction

  logic [2:0]  sb_phase = '0;
  logic [31:0] sb_in = '0;
  logic [31:0] sb_in2 = '0;

  always @(posedge clk) begin
    sb_phase <= (sb_phase == 3'd4) ? 3'd0 : sb_phase + 3'd1;
    if (sb_phase == 3'd0) begin
      sb_in  <= sboxw;
      sb_in2 <= sboxw2;
    end else begin
      new_sboxw[8*(int'(sb_phase)-1) +: 8]  <= sub_byte(sb_in[8*(int'(sb_phase)-1) +: 8]);
      new_sboxw2[8*(int'(sb_phase)-1) +: 8] <= sub_byte(sb_in2[8*(int'(sb_phase)-1) +: 8]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- expected vectors ----------------
  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2_FIPS  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam int LAT1 = 110;
  localparam int LAT2 = 130;

  // ---------------- driver tasks ----------------
  task automatic read_rk(input logic [3:0] r, output logic [127:0] a, output logic [127:0] b);
    @(negedge clk);
    round = r;
    @(posedge clk);
    #1;
    a = round_key;
    b = round_key2;
  endtask

  // Starts an expansion at a chosen offset from S-box phase 0.
  // A nonzero inject_at pulses init with another key on that edge after start.
  // The task returns the cycle count until each ready rises, or -1 on timeout.
  task automatic run_expansion(input logic [127:0] k, input int off, input int inject_at,
                               output int lat1, output int lat2);
    int c;
    c = 0;
    lat1 = -1;
    lat2 = -1;
    @(negedge clk);
    for (int i = 0; i < 5 && sb_phase != 3'd0; i++) @(negedge clk);
    repeat (off) @(negedge clk);
    init = 1'b1;
    key  = k;
    @(posedge clk);
    #1;
    check("ready_low_after_init", {127'h0, ready}, 128'h0);
    check("ready2_low_after_init", {127'h0, ready2}, 128'h0);
    while (c < 300 && (lat1 < 0 || lat2 < 0)) begin
      @(negedge clk);
      init = (c + 1 == inject_at);
      if (init) key = ~k;
      @(posedge clk);
      c++;
      #1;
      if (ready  && lat1 < 0) lat1 = c;
      if (ready2 && lat2 < 0) lat2 = c;
    end
    @(negedge clk);
    init = 1'b0;
  endtask

  // Reads rounds 0, 1 and 10 from both instances and compares them with the queue.
  task automatic check_keys(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                            input logic [127:0] e10);
    logic [127:0] a, b, e;
    logic [3:0] rr [3];
    rr[0] = 4'd0;
    rr[1] = 4'd1;
    rr[2] = 4'd10;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e10);
    for (int i = 0; i < 3; i++) begin
      read_rk(rr[i], a, b);
      e = exp_q.pop_front();
      check($sformatf("%s_rk%0d", tag, rr[i]), a, e);
      check($sformatf("%s_rk%0d_w12", tag, rr[i]), b, e);
    end
  endtask

  task automatic check_lat(input string tag, input int l1, input int l2);
    check({tag, "_latency"}, 128'(l1), 128'(LAT1));
    check({tag, "_latency_w12"}, 128'(l2), 128'(LAT2));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int l1, l2;
    logic [127:0] a, b;

    // Reset state
    #1;
    check("reset_ready", {127'h0, ready}, 128'h0);
    check("reset_sboxw", {96'h0, sboxw}, 128'h0);
    check("reset_round_key", round_key, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_rk(4'd5, a, b);
    check("reset_rk5", a, 128'h0);

    // T1: FIPS-197 key
    run_expansion(KEY_FIPS, 0, 0, l1, l2);
    check_lat("t1", l1, l2);
    check_keys("t1", KEY_FIPS, RK1_FIPS, RK10_FIPS);
    read_rk(4'd2, a, b);
    check("t1_rk2", a, RK2_FIPS);
    check("t1_ready_held", {127'h0, ready}, 128'h1);

    // T4 and T2: restart from DONE with the zero key
    run_expansion(128'h0, 0, 0, l1, l2);
    check_lat("t2", l1, l2);
    check_keys("t2", 128'h0, RK1_ZERO, RK10_ZERO);
    for (int r = 11; r < 16; r++) begin
      read_rk(4'(r), a, b);
      check($sformatf("t4_round%0d_zero", r), a, 128'h0);
    end

    // T3: an init pulse during the expansion is ignored
    run_expansion(KEY_FIPS, 0, 30, l1, l2);
    check_lat("t3", l1, l2);
    check_keys("t3", KEY_FIPS, RK1_FIPS, RK10_FIPS);

    // T5: reset in the middle of a run
    run_expansion(128'h0, 0, 0, l1, l2);
    @(negedge clk);
    init = 1'b1;
    key  = KEY_FIPS;
    @(negedge clk);
    init = 1'b0;
    repeat (49) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ready_async", {127'h0, ready}, 128'h0);
    check("t5_sboxw_async", {96'h0, sboxw}, 128'h0);
    check("t5_round_key_async", round_key, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_rk(4'd1, a, b);
    check("t5_rk1_cleared", a, 128'h0);
    run_expansion(KEY_FIPS, 0, 0, l1, l2);
    check_lat("t5", l1, l2);
    check_keys("t5", KEY_FIPS, RK1_FIPS, RK10_FIPS);

    // T6: start at each offset from the S-box phase
    for (int off = 0; off < 5; off++) begin
      run_expansion(KEY_FIPS, off, 0, l1, l2);
      check_lat($sformatf("t6_off%0d", off), l1, l2);
      check_keys($sformatf("t6_off%0d", off), KEY_FIPS, RK1_FIPS, RK10_FIPS);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
